// File: rtl/sysid_check_ctrl.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = timestamp),
// compares both words against expected constants and reports the result to boot logic.
module sysid_check_ctrl #(
    parameter logic [31:0] EXPECTED_ID  = 32'hACD51302,
    parameter logic [31:0] EXPECTED_TS  = 32'h57117CE3,
    parameter int          READ_LATENCY = 0,
    parameter int          TIMEOUT      = 255,
    parameter int          POLL_PERIOD  = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_ID  = 3'd1;
    localparam logic [2:0] S_LAT_ID = 3'd2;
    localparam logic [2:0] S_RD_TS  = 3'd3;
    localparam logic [2:0] S_LAT_TS = 3'd4;
    localparam logic [2:0] S_CHECK  = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    logic [2:0]  state_reg;
    logic [2:0]  state_next;
    logic [15:0] stall_reg;
    logic [2:0]  lat_reg;
    logic [31:0] id_cap_reg;
    logic [31:0] ts_cap_reg;
    logic        poll_hit;
    logic        rd_phase;
    logic        accept;
    logic        stall_expired;
    logic        lat_last;
    logic        cap_id;
    logic        cap_ts;

    assign rd_phase      = (state_reg == S_RD_ID) || (state_reg == S_RD_TS);
    assign accept        = rd_phase && !avm_waitrequest;
    // The cycle that would push the stall count to TIMEOUT is the last one with avm_read high.
    assign stall_expired = rd_phase && avm_waitrequest && (stall_reg == 16'(TIMEOUT - 1));
    assign lat_last      = ((state_reg == S_LAT_ID) || (state_reg == S_LAT_TS))
                           && (lat_reg == 3'(READ_LATENCY - 1));

    assign cap_id = ((state_reg == S_RD_ID) && accept && (READ_LATENCY == 0))
                    || ((state_reg == S_LAT_ID) && lat_last);
    assign cap_ts = ((state_reg == S_RD_TS) && accept && (READ_LATENCY == 0))
                    || ((state_reg == S_LAT_TS) && lat_last);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start || poll_hit) state_next = S_RD_ID;
            end
            S_RD_ID: begin
                if (stall_expired)     state_next = S_FIN;
                else if (accept)       state_next = (READ_LATENCY == 0) ? S_RD_TS : S_LAT_ID;
            end
            S_LAT_ID: begin
                if (lat_last)          state_next = S_RD_TS;
            end
            S_RD_TS: begin
                if (stall_expired)     state_next = S_FIN;
                else if (accept)       state_next = (READ_LATENCY == 0) ? S_CHECK : S_LAT_TS;
            end
            S_LAT_TS: begin
                if (lat_last)          state_next = S_CHECK;
            end
            S_CHECK:                   state_next = S_FIN;
            S_FIN:                     state_next = S_IDLE;
            default:                   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            stall_reg   <= '0;
            lat_reg     <= '0;
            id_cap_reg  <= '0;
            ts_cap_reg  <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state_reg <= state_next;

            if (!rd_phase || accept) stall_reg <= '0;
            else                     stall_reg <= stall_reg + 16'd1;

            if (((state_reg == S_LAT_ID) || (state_reg == S_LAT_TS)) && !lat_last)
                lat_reg <= lat_reg + 3'd1;
            else
                lat_reg <= '0;

            if (cap_id) id_cap_reg <= avm_readdata;
            if (cap_ts) ts_cap_reg <= avm_readdata;

            // Published results only move at the end of CHECK or on an abort.
            if (state_reg == S_CHECK) begin
                id_ok       <= (id_cap_reg == EXPECTED_ID);
                ts_ok       <= (ts_cap_reg == EXPECTED_TS);
                id_value    <= id_cap_reg;
                ts_value    <= ts_cap_reg;
                timeout_err <= 1'b0;
            end else if (stall_expired) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end

    generate
        if (POLL_PERIOD != 0) begin : g_poll
            logic [31:0] poll_reg;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    poll_reg <= '0;
                else if ((state_reg != S_IDLE) || (state_next != S_IDLE))
                    poll_reg <= '0;
                else
                    poll_reg <= poll_reg + 32'd1;
            end

            assign poll_hit = (state_reg == S_IDLE) && (poll_reg == 32'(POLL_PERIOD - 1));
        end else begin : g_no_poll
            assign poll_hit = 1'b0;
        end
    endgenerate

    assign avm_read    = rd_phase;
    assign avm_address = (state_reg == S_RD_TS);
    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_FIN);

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Directed bench for sysid_check_ctrl: three instances cover zero-latency checks and timeouts,
// stalls with READ_LATENCY=2, and periodic polling.
module tb_sysid_check_ctrl;

    localparam logic [31:0] EXP_ID = 32'hACD51302;
    localparam logic [31:0] EXP_TS = 32'h57117CE3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instance A: latency 0, TIMEOUT 4, no polling
    logic        rst_a_n, start_a, addr_a, read_a, wait_a, busy_a, done_a, idok_a, tsok_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a, slave_id_a, slave_ts_a;
    assign rdata_a = addr_a ? slave_ts_a : slave_id_a;

    sysid_check_ctrl #(.READ_LATENCY(0), .TIMEOUT(4), .POLL_PERIOD(0)) u_a (
        .clock(clock), .reset_n(rst_a_n), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wait_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(idok_a), .ts_ok(tsok_a), .timeout_err(to_a),
        .id_value(idv_a), .ts_value(tsv_a));

    // Instance B: latency 2, slave stalls 3 cycles per read, data valid only on the 2nd cycle after acceptance
    logic        rst_b_n, start_b, addr_b, read_b, wait_b, busy_b, done_b, idok_b, tsok_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    int          ws_b = 0;
    int          age_b = 0;
    logic        last_addr_b = 1'b0;

    always @(posedge clock) begin
        if (read_b && !wait_b) begin
            last_addr_b <= addr_b;
            age_b       <= 1;
        end else if (age_b == 1) begin
            age_b <= 2;
        end else begin
            age_b <= 0;
        end
        if (read_b && wait_b) ws_b <= ws_b + 1;
        else if (read_b)      ws_b <= 0;
    end
    assign wait_b  = (ws_b < 3);
    assign rdata_b = (age_b == 2) ? (last_addr_b ? EXP_TS : EXP_ID) : 32'hDEADBEEF;

    sysid_check_ctrl #(.READ_LATENCY(2), .TIMEOUT(255), .POLL_PERIOD(0)) u_b (
        .clock(clock), .reset_n(rst_b_n), .start(start_b),
        .avm_address(addr_b), .avm_read(read_b), .avm_waitrequest(wait_b), .avm_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(idok_b), .ts_ok(tsok_b), .timeout_err(to_b),
        .id_value(idv_b), .ts_value(tsv_b));

    // Instance C: polling every 10 idle cycles
    logic        rst_c_n, start_c, addr_c, read_c, wait_c, busy_c, done_c, idok_c, tsok_c, to_c;
    logic [31:0] rdata_c, idv_c, tsv_c;
    assign wait_c  = 1'b0;
    assign rdata_c = addr_c ? EXP_TS : EXP_ID;

    sysid_check_ctrl #(.READ_LATENCY(0), .TIMEOUT(255), .POLL_PERIOD(10)) u_c (
        .clock(clock), .reset_n(rst_c_n), .start(start_c),
        .avm_address(addr_c), .avm_read(read_c), .avm_waitrequest(wait_c), .avm_readdata(rdata_c),
        .busy(busy_c), .done(done_c), .id_ok(idok_c), .ts_ok(tsok_c), .timeout_err(to_c),
        .id_value(idv_c), .ts_value(tsv_c));

    typedef struct {
        logic [31:0] id_word;
        logic [31:0] ts_word;
        logic        exp_id_ok;
        logic        exp_ts_ok;
    } vec_t;

    vec_t vecs[7];

    // Pulses start on A and returns the cycle index (start cycle = 0) at which done was seen.
    task automatic run_a(input logic [31:0] idw, input logic [31:0] tsw, output int n);
        slave_id_a = idw;
        slave_ts_a = tsw;
        start_a    = 1'b1;
        n          = 0;
        do begin
            @(negedge clock);
            start_a = 1'b0;
            n++;
        end while (!done_a && n < 20);
        if (!done_a) begin
            failures++;
            checks++;
            $display("FAIL run_a_timeout: no done within %0d cycles", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int done_cnt;
        int rd_starts;
        int first_rd, second_rd, first_done, second_done;
        logic prev_rd;
        logic exp_rd;

        vecs[0] = '{EXP_ID,       EXP_TS,       1'b1, 1'b1};
        vecs[1] = '{EXP_ID,       32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{EXP_ID,       EXP_TS,       1'b1, 1'b1};
        vecs[3] = '{32'h00000000, EXP_TS,       1'b0, 1'b1};
        vecs[4] = '{32'hACD51303, 32'h57117CE2, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[6] = '{EXP_ID,       EXP_TS,       1'b1, 1'b1};

        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        wait_a  = 1'b0;
        slave_id_a = EXP_ID;
        slave_ts_a = EXP_TS;

        repeat (3) @(negedge clock);
        check1 ("rst_busy",     busy_a, 1'b0);
        check1 ("rst_done",     done_a, 1'b0);
        check1 ("rst_read",     read_a, 1'b0);
        check1 ("rst_addr",     addr_a, 1'b0);
        check1 ("rst_id_ok",    idok_a, 1'b0);
        check1 ("rst_ts_ok",    tsok_a, 1'b0);
        check1 ("rst_timeout",  to_a,   1'b0);
        check32("rst_id_value", idv_a,  32'h0);
        check32("rst_ts_value", tsv_a,  32'h0);
        check1 ("rst_c_busy",   busy_c, 1'b0);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(negedge clock);

        // Cycle-accurate basic check; a start during FIN must be ignored.
        start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;                  // cycle 1
        check1("c1_read", read_a, 1'b1);
        check1("c1_addr", addr_a, 1'b0);
        check1("c1_busy", busy_a, 1'b1);
        @(negedge clock);                                  // cycle 2
        check1("c2_read", read_a, 1'b1);
        check1("c2_addr", addr_a, 1'b1);
        @(negedge clock);                                  // cycle 3 (CHECK)
        check1("c3_read",  read_a, 1'b0);
        check1("c3_done",  done_a, 1'b0);
        check1("c3_id_ok_hold", idok_a, 1'b0);
        @(negedge clock);                                  // cycle 4 (FIN)
        check1 ("c4_done",    done_a, 1'b1);
        check1 ("c4_id_ok",   idok_a, 1'b1);
        check1 ("c4_ts_ok",   tsok_a, 1'b1);
        check1 ("c4_timeout", to_a,   1'b0);
        check32("c4_id_value", idv_a, EXP_ID);
        check32("c4_ts_value", tsv_a, EXP_TS);
        start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;                  // cycle 5
        check1("c5_busy", busy_a, 1'b0);
        check1("c5_done", done_a, 1'b0);
        @(negedge clock);                                  // cycle 6
        check1("fin_start_ignored", busy_a, 1'b0);
        $display("seq basic: id=%h ts=%h id_ok=%b ts_ok=%b", idv_a, tsv_a, idok_a, tsok_a);

        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i].id_word, vecs[i].ts_word, n);
            check32("vec_done_cycle", 32'(n), 32'd4);
            check1 ("vec_id_ok",   idok_a, vecs[i].exp_id_ok);
            check1 ("vec_ts_ok",   tsok_a, vecs[i].exp_ts_ok);
            check1 ("vec_timeout", to_a,   1'b0);
            check32("vec_id_value", idv_a, vecs[i].id_word);
            check32("vec_ts_value", tsv_a, vecs[i].ts_word);
            $display("vec %0d: id=%h ts=%h id_ok=%b ts_ok=%b done_cycle=%0d",
                     i, idv_a, tsv_a, idok_a, tsok_a, n);
            @(negedge clock);
        end

        // Timeout: waitrequest stuck high, TIMEOUT=4.
        wait_a   = 1'b1;
        done_cnt = 0;
        start_a  = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            start_a = 1'b0;
            if (done_a) done_cnt++;
            if (c <= 4) begin
                check1("to_read_held", read_a, 1'b1);
                check1("to_addr_held", addr_a, 1'b0);
                check1("to_no_done",   done_a, 1'b0);
            end
            if (c == 5) begin
                check1 ("to_read_drop",  read_a, 1'b0);
                check1 ("to_done",       done_a, 1'b1);
                check1 ("to_err",        to_a,   1'b1);
                check1 ("to_id_ok",      idok_a, 1'b0);
                check1 ("to_ts_ok",      tsok_a, 1'b0);
                check32("to_id_kept",    idv_a,  EXP_ID);
                check32("to_ts_kept",    tsv_a,  EXP_TS);
            end
        end
        check32("to_done_pulses", 32'(done_cnt), 32'd1);
        check1 ("to_idle", busy_a, 1'b0);
        $display("seq timeout: timeout_err=%b done_pulses=%0d", to_a, done_cnt);
        wait_a = 1'b0;

        run_a(EXP_ID, EXP_TS, n);
        check1("recover_timeout_clr", to_a,   1'b0);
        check1("recover_id_ok",       idok_a, 1'b1);
        @(negedge clock);

        // Asynchronous reset while reading the timestamp.
        start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
        @(negedge clock);
        check1("mid_in_rd_ts", addr_a, 1'b1);
        #1 rst_a_n = 1'b0;
        #1;
        check1 ("mid_rst_busy",  busy_a, 1'b0);
        check1 ("mid_rst_read",  read_a, 1'b0);
        check1 ("mid_rst_addr",  addr_a, 1'b0);
        check1 ("mid_rst_done",  done_a, 1'b0);
        check1 ("mid_rst_id_ok", idok_a, 1'b0);
        check1 ("mid_rst_ts_ok", tsok_a, 1'b0);
        check32("mid_rst_id_value", idv_a, 32'h0);
        check32("mid_rst_ts_value", tsv_a, 32'h0);
        @(negedge clock);
        rst_a_n  = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (done_a || busy_a) done_cnt++;
        end
        check32("mid_rst_no_activity", 32'(done_cnt), 32'd0);
        run_a(EXP_ID, EXP_TS, n);
        check32("after_rst_done_cycle", 32'(n), 32'd4);
        check1 ("after_rst_id_ok", idok_a, 1'b1);
        $display("seq reset: done_cycle=%0d id_ok=%b", n, idok_a);
        @(negedge clock);

        // Instance B: 3 wait-states per read, READ_LATENCY=2 -> done at cycle 4+3+3+2+2 = 14.
        start_b = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clock);
            start_b = 1'b0;
            exp_rd = ((c >= 1) && (c <= 4)) || ((c >= 7) && (c <= 10));
            check1("lat_read", read_b, exp_rd);
            if (exp_rd) check1("lat_addr", addr_b, (c >= 7));
            check1("lat_done", done_b, (c == 14));
            if (c == 14) begin
                check1 ("lat_id_ok", idok_b, 1'b1);
                check1 ("lat_ts_ok", tsok_b, 1'b1);
                check32("lat_id_value", idv_b, EXP_ID);
                check32("lat_ts_value", tsv_b, EXP_TS);
            end
        end
        $display("seq latency: id=%h ts=%h id_ok=%b ts_ok=%b", idv_b, tsv_b, idok_b, tsok_b);

        // Instance C: polling, with a start pulse while busy that must not be queued.
        @(negedge clock);
        rst_c_n   = 1'b1;
        prev_rd   = 1'b0;
        rd_starts = 0;
        first_rd  = 0; second_rd = 0; first_done = 0; second_done = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            start_c = (k == 11);
            if (read_c && !prev_rd) begin
                rd_starts++;
                if (rd_starts == 1) first_rd = k;
                if (rd_starts == 2) second_rd = k;
            end
            if (read_c && addr_c) prev_rd = 1'b0;
            else                  prev_rd = read_c;
            if (done_c) begin
                if (first_done == 0) first_done = k;
                else if (second_done == 0) second_done = k;
            end
        end
        start_c = 1'b0;
        check32("poll_first_start",  32'(first_rd),    32'd10);
        check32("poll_first_done",   32'(first_done),  32'd13);
        check32("poll_second_start", 32'(second_rd),   32'd24);
        check32("poll_second_done",  32'(second_done), 32'd27);
        check32("poll_start_count",  32'(rd_starts),   32'd2);
        check1 ("poll_id_ok", idok_c, 1'b1);
        $display("seq poll: starts=%0d first=%0d second=%0d", rd_starts, first_rd, second_rd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
